// File: rtl/controlador_cafe_if.sv
// controlador_cafe_if -- coin, purchase and dispenser signals of the coffee
// vending controller, grouped as one bundle.
//   slave  : controller side (controlador_cafe)
//   master : environment side (coin acceptor, keypad, dispenser)
// Inputs to controller : moneda100, moneda500, pedir, seleccion[1:0],
//                        cancelar, listo
// Outputs of controller: credito[N-1:0], dispensar, producto[1:0],
//                        devuelve100, fondos_insuficientes,
//                        rechazo_moneda, ocupado
interface controlador_cafe_if #(
  parameter int unsigned N = 4
) ();
  logic         moneda100;
  logic         moneda500;
  logic         pedir;
  logic [1:0]   seleccion;
  logic         cancelar;
  logic         listo;
  logic [N-1:0] credito;
  logic         dispensar;
  logic [1:0]   producto;
  logic         devuelve100;
  logic         fondos_insuficientes;
  logic         rechazo_moneda;
  logic         ocupado;

  modport slave (
    input  moneda100, moneda500, pedir, seleccion, cancelar, listo,
    output credito, dispensar, producto, devuelve100,
           fondos_insuficientes, rechazo_moneda, ocupado
  );

  modport master (
    output moneda100, moneda500, pedir, seleccion, cancelar, listo,
    input  credito, dispensar, producto, devuelve100,
           fondos_insuficientes, rechazo_moneda, ocupado
  );
endinterface

// File: rtl/controlador_cafe.sv
// controlador_cafe -- coffee vending controller.
// Accumulates credit from 100/500 coins (saturating at 2^N-1), sells one of
// four products priced PRECIO_0..PRECIO_3 (in 100-units), holds the dispense
// request until the dispenser acknowledges, and optionally returns change.
// Ports:
//   clk   : sole clock, rising edge
//   reset : synchronous, active-high
//   bus   : controlador_cafe_if.slave (coins, request, cancel, dispenser
//           handshake, credit and status outputs)
// All outputs are registered.
// Optional feature macro: DEVOLVER_CAMBIO_EN -- enables the CAMBIO state,
// which returns remaining credit as devuelve100 pulses after a dispense or
// cancel. Without it, devuelve100 is tied low, leftover credit is kept after
// a dispense and cancelar simply clears the credit.
module controlador_cafe #(
  parameter int unsigned N        = 4,
  parameter int unsigned PRECIO_0 = 3,
  parameter int unsigned PRECIO_1 = 4,
  parameter int unsigned PRECIO_2 = 6,
  parameter int unsigned PRECIO_3 = 5
) (
  input  logic                clk,
  input  logic                reset,
  controlador_cafe_if.slave   bus
);

  typedef enum logic [1:0] {
`ifdef DEVOLVER_CAMBIO_EN
    CAMBIO   = 2'd2,
`endif
    ESPERA   = 2'd0,
    DISPENSA = 2'd1
  } estado_t;

  // Wide enough that credit + coin and any 32-bit price never overflow.
  localparam int unsigned W = N + 32;
  localparam logic [N-1:0] CRED_MAX = '1;

  estado_t      estado_q;
  logic [N-1:0] credito_q;
  logic         dispensar_q;
  logic [1:0]   producto_q;
  logic         fondos_q;
  logic         rechazo_q;
`ifdef DEVOLVER_CAMBIO_EN
  logic         devuelve_q;
`endif

  logic [W-1:0] precio_sel;
  logic [W-1:0] valor_moneda;
  logic [W-1:0] suma;
  logic [N-1:0] credito_sumado;
  logic [N-1:0] credito_restado;
  logic         alcanza;
  logic         hay_moneda;

  always_comb begin
    precio_sel = '0;
    case (bus.seleccion)
      2'd0:    precio_sel = W'(PRECIO_0);
      2'd1:    precio_sel = W'(PRECIO_1);
      2'd2:    precio_sel = W'(PRECIO_2);
      default: precio_sel = W'(PRECIO_3);
    endcase
  end

  always_comb begin
    valor_moneda = '0;
    case ({bus.moneda500, bus.moneda100})
      2'b01:   valor_moneda = W'(1);
      2'b10:   valor_moneda = W'(5);
      2'b11:   valor_moneda = W'(6);
      default: valor_moneda = '0;
    endcase
  end

  assign hay_moneda      = bus.moneda100 | bus.moneda500;
  assign suma            = W'(credito_q) + valor_moneda;
  assign credito_sumado  = (suma > W'(CRED_MAX)) ? CRED_MAX : suma[N-1:0];
  assign alcanza         = (W'(credito_q) >= precio_sel);
  // Only used when alcanza holds, so the price fits in N bits here.
  assign credito_restado = credito_q - precio_sel[N-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q    <= ESPERA;
      credito_q   <= '0;
      dispensar_q <= 1'b0;
      producto_q  <= '0;
      fondos_q    <= 1'b0;
      rechazo_q   <= 1'b0;
`ifdef DEVOLVER_CAMBIO_EN
      devuelve_q  <= 1'b0;
`endif
    end else begin
      fondos_q    <= 1'b0;
      rechazo_q   <= 1'b0;
`ifdef DEVOLVER_CAMBIO_EN
      devuelve_q  <= 1'b0;
`endif
      case (estado_q)
        ESPERA: begin
          if (bus.cancelar) begin
            // Cancel wins over pedir; coins in this cycle are refused.
            rechazo_q <= hay_moneda;
`ifdef DEVOLVER_CAMBIO_EN
            if (credito_q != '0) estado_q <= CAMBIO;
`else
            credito_q <= '0;
`endif
          end else if (bus.pedir) begin
            if (alcanza) begin
              credito_q   <= credito_restado;
              producto_q  <= bus.seleccion;
              dispensar_q <= 1'b1;
              rechazo_q   <= hay_moneda;
              estado_q    <= DISPENSA;
            end else begin
              // Refused request: a coin in the same cycle still counts.
              fondos_q  <= 1'b1;
              credito_q <= credito_sumado;
            end
          end else begin
            credito_q <= credito_sumado;
          end
        end

        DISPENSA: begin
          rechazo_q <= hay_moneda;
          if (bus.listo) begin
            dispensar_q <= 1'b0;
`ifdef DEVOLVER_CAMBIO_EN
            estado_q    <= (credito_q != '0) ? CAMBIO : ESPERA;
`else
            estado_q    <= ESPERA;
`endif
          end
        end

`ifdef DEVOLVER_CAMBIO_EN
        CAMBIO: begin
          rechazo_q <= hay_moneda;
          if (credito_q != '0) begin
            devuelve_q <= 1'b1;
            credito_q  <= credito_q - N'(1);
          end
          // Leave on the pulse that empties the credit.
          if (credito_q <= N'(1)) estado_q <= ESPERA;
        end
`endif

        default: estado_q <= ESPERA;
      endcase
    end
  end

  assign bus.credito              = credito_q;
  assign bus.dispensar            = dispensar_q;
  assign bus.producto             = producto_q;
  assign bus.fondos_insuficientes = fondos_q;
  assign bus.rechazo_moneda       = rechazo_q;
  assign bus.ocupado              = (estado_q != ESPERA);
`ifdef DEVOLVER_CAMBIO_EN
  assign bus.devuelve100          = devuelve_q;
`else
  assign bus.devuelve100          = 1'b0;
`endif

endmodule

// File: tb/tb_controlador_cafe.sv
module tb_controlador_cafe;
  localparam int N   = 4;
  localparam int MAXC = (1 << N) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  controlador_cafe_if #(.N(N)) bus ();

  controlador_cafe #(
    .N(N), .PRECIO_0(3), .PRECIO_1(4), .PRECIO_2(6), .PRECIO_3(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct packed {
    logic [N-1:0] credito;
    logic         dispensar;
    logic [1:0]   producto;
    logic         devuelve100;
    logic         fondos;
    logic         rechazo;
    logic         ocupado;
  } obs_t;

  obs_t exp_q[$];
  int tests = 0;
  int fails = 0;

  // Reference model: credit as a plain integer plus an activity phase.
  int price [4] = '{3, 4, 6, 5};
  int credit = 0;
  int prod   = 0;
  int phase  = 0;   // 0 idle, 1 serving a cup, 2 paying back change
`ifdef DEVOLVER_CAMBIO_EN
  bit change_on = 1'b1;
`else
  bit change_on = 1'b0;
`endif

  task automatic cyc(input bit r, input bit m1, input bit m5, input bit p,
                     input int sel, input bit c, input bit l);
    obs_t e;
    int coin;
    bit refuse, broke, payback;
    @(negedge clk);
    reset             = r;
    bus.moneda100     = m1;
    bus.moneda500     = m5;
    bus.pedir         = p;
    bus.seleccion     = 2'(sel);
    bus.cancelar      = c;
    bus.listo         = l;
    coin    = (m1 ? 1 : 0) + (m5 ? 5 : 0);
    refuse  = 1'b0;
    broke   = 1'b0;
    payback = 1'b0;
    if (r) begin
      credit = 0; prod = 0; phase = 0;
    end else if (phase == 0) begin
      if (c) begin
        refuse = (coin != 0);
        if (change_on) phase = (credit > 0) ? 2 : 0;
        else credit = 0;
      end else if (p && credit >= price[sel]) begin
        credit = credit - price[sel];
        prod   = sel;
        phase  = 1;
        refuse = (coin != 0);
      end else begin
        broke  = p;
        credit = (credit + coin > MAXC) ? MAXC : credit + coin;
      end
    end else if (phase == 1) begin
      refuse = (coin != 0);
      if (l) phase = (change_on && credit > 0) ? 2 : 0;
    end else begin
      refuse  = (coin != 0);
      payback = 1'b1;
      credit  = credit - 1;
      if (credit == 0) phase = 0;
    end
    e.credito     = N'(credit);
    e.dispensar   = (phase == 1);
    e.producto    = 2'(prod);
    e.devuelve100 = payback;
    e.fondos      = broke;
    e.rechazo     = refuse;
    e.ocupado     = (phase != 0);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every registered output sample is compared with the queued
  // expectation for that edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        obs_t e, g;
        e = exp_q.pop_front();
        g.credito     = bus.credito;
        g.dispensar   = bus.dispensar;
        g.producto    = bus.producto;
        g.devuelve100 = bus.devuelve100;
        g.fondos      = bus.fondos_insuficientes;
        g.rechazo     = bus.rechazo_moneda;
        g.ocupado     = bus.ocupado;
        tests++;
        if (g !== e) begin
          fails++;
          $display("FAIL outputs t=%0t got cred=%0d disp=%b prod=%0d dev=%b fondos=%b rech=%b ocup=%b ; expected cred=%0d disp=%b prod=%0d dev=%b fondos=%b rech=%b ocup=%b",
                   $time, g.credito, g.dispensar, g.producto, g.devuelve100, g.fondos, g.rechazo, g.ocupado,
                   e.credito, e.dispensar, e.producto, e.devuelve100, e.fondos, e.rechazo, e.ocupado);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.moneda100 = 0; bus.moneda500 = 0; bus.pedir = 0;
    bus.seleccion = 0; bus.cancelar = 0; bus.listo = 0;

    // Basic purchase: 500, 100, buy product 2, acknowledge.
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 2, 0, 0);
    idle(2);
    cyc(0, 0, 0, 0, 0, 0, 1);
    idle(2);

    // Saturation and simultaneous coins.
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0);

    // Insufficient funds, with and without a coin in the same cycle.
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0, 0);
    idle(1);

    // Credit 7, buy product 1, slow acknowledge, coin while dispensing.
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    idle(2);
    cyc(0, 0, 0, 0, 0, 0, 1);
    idle(5);

    // Coin with an accepted request is refused.
    cyc(0, 1, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 3, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    idle(3);

    // pedir + cancelar with credit 5, coin refused.
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 1, 0);
    idle(7);

    // Reset in the middle of paying back change (credit 4 left).
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    idle(4);
    cyc(1, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 5) == 0,
          $urandom_range(0, 5) == 0,
          int'($urandom_range(0, 3)),
          $urandom_range(0, 24) == 0,
          $urandom_range(0, 2) == 0);
    end
    idle(1);

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
